// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and oversampling constants
// shared by the UART core and its tick generator.
package uart_pkg;

  localparam int OVS        = 16;
  localparam int OVS_MID    = 8;
  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversample tick, one clk wide every baud_div+1 clks.
// Ports: clk, rst, baud_div (reload value), tick16 (out).
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick16
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // baud_div is only read at reload, so a change never cuts a period short
  always_comb begin
    tick16 = (cnt_q == '0);
    cnt_d  = tick16 ? baud_div : cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART, DATA_W data bits, 1/2 stop bits,
// 16x rx oversampling. Ports: clk, rst, baud_div, stop2, par_en, par_odd,
// tx_data/tx_valid/tx_ready/tx, rx/rx_data/rx_valid/rx_ready,
// rx_ferr/rx_perr/rx_ovr. Parity logic exists only with UART_PARITY_EN.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              stop2,
  input  logic              par_en,
  input  logic              par_odd,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_ferr,
  output logic              rx_perr,
  output logic              rx_ovr
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_w_chk
    $error("uart_core_param: DATA_W out of range");
  end

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);
  localparam logic [3:0] OVS_END  = 4'(OVS - 1);
  localparam logic [3:0] MID_END  = 4'(OVS_MID - 1);

  logic tick16;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .tick16   (tick16)
  );

  tx_state_e         tx_st_q, tx_st_d;
  logic [3:0]        tx_ovs_q, tx_ovs_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_stop2_q, tx_stop2_d;
  logic              tx_q, tx_d;
  logic              tx_bit_end;

  rx_state_e         rx_st_q, rx_st_d;
  logic              rx_s1_q, rx_s2_q, rx_s3_q;
  logic [3:0]        rx_ovs_q, rx_ovs_d;
  logic [3:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_ferr_q, rx_ferr_d;
  logic              rx_ovr_q, rx_ovr_d;
  logic              rx_fall, rx_mid, rx_bit_end;

`ifdef UART_PARITY_EN
  logic tx_pen_q, tx_pen_d;
  logic tx_par_q, tx_par_d;
  logic rx_pen_q, rx_pen_d;
  logic rx_odd_q, rx_odd_d;
  logic rx_pbad_q, rx_pbad_d;
  logic rx_perr_q, rx_perr_d;
  assign rx_perr = rx_perr_q;
`else
  logic unused_par;
  assign unused_par = ^{par_en, par_odd};
  assign rx_perr    = 1'b0;
`endif

  assign tx_ready = (tx_st_q == TX_IDLE);
  assign tx       = tx_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_ferr  = rx_ferr_q;
  assign rx_ovr   = rx_ovr_q;

  assign tx_bit_end = tick16 && (tx_ovs_q == OVS_END);

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_ovs_d   = tx_ovs_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_stop2_d = tx_stop2_q;
`ifdef UART_PARITY_EN
    tx_pen_d   = tx_pen_q;
    tx_par_d   = tx_par_q;
`endif
    if (tx_st_q != TX_IDLE && tick16)
      tx_ovs_d = tx_ovs_q + 1'b1;
    case (tx_st_q)
      TX_IDLE: if (tx_valid) begin
        tx_st_d    = TX_START;
        tx_ovs_d   = '0;
        tx_bit_d   = '0;
        tx_sh_d    = tx_data;
        tx_stop2_d = stop2;
`ifdef UART_PARITY_EN
        tx_pen_d   = par_en;
        tx_par_d   = ^tx_data ^ par_odd;
`endif
      end
      TX_START: if (tx_bit_end) tx_st_d = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == LAST_BIT) begin
          tx_bit_d = '0;
`ifdef UART_PARITY_EN
          tx_st_d  = tx_pen_q ? TX_PAR : TX_STOP;
`else
          tx_st_d  = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PAR: if (tx_bit_end) tx_st_d = TX_STOP;
`endif
      TX_STOP: if (tx_bit_end) begin
        // tx_bit_q counts stop bits already sent
        if (tx_stop2_q && tx_bit_q == '0) tx_bit_d = 4'd1;
        else                              tx_st_d  = TX_IDLE;
      end
      default: tx_st_d = TX_IDLE;
    endcase
    // line level follows the next state so it switches with the FSM
    case (tx_st_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_sh_d[0];
`ifdef UART_PARITY_EN
      TX_PAR:   tx_d = tx_par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // a start needs a 1->0 edge, so a line held low after a break
  // cannot re-arm the receiver until it has returned high
  assign rx_fall    = rx_s3_q & ~rx_s2_q;
  assign rx_mid     = tick16 && (rx_ovs_q == MID_END);
  assign rx_bit_end = tick16 && (rx_ovs_q == OVS_END);

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_ovs_d   = rx_ovs_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = 1'b0;
`ifdef UART_PARITY_EN
    rx_pen_d   = rx_pen_q;
    rx_odd_d   = rx_odd_q;
    rx_pbad_d  = rx_pbad_q;
    rx_perr_d  = rx_perr_q;
`endif
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (rx_st_q != RX_IDLE && tick16)
      rx_ovs_d = rx_ovs_q + 1'b1;
    case (rx_st_q)
      RX_IDLE: if (rx_fall) begin
        rx_st_d  = RX_START;
        rx_ovs_d = '0;
        rx_bit_d = '0;
`ifdef UART_PARITY_EN
        rx_pen_d  = par_en;
        rx_odd_d  = par_odd;
        rx_pbad_d = 1'b0;
`endif
      end
      RX_START: if (rx_mid) begin
        rx_ovs_d = '0;
        rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == LAST_BIT) begin
          rx_bit_d = '0;
`ifdef UART_PARITY_EN
          rx_st_d  = rx_pen_q ? RX_PAR : RX_STOP;
`else
          rx_st_d  = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PAR: if (rx_bit_end) begin
        rx_pbad_d = rx_s2_q ^ (^rx_sh_q) ^ rx_odd_q;
        rx_st_d   = RX_STOP;
      end
`endif
      RX_STOP: if (rx_bit_end) begin
        rx_st_d    = RX_IDLE;
        rx_data_d  = rx_sh_q;
        rx_ferr_d  = ~rx_s2_q;
        rx_valid_d = 1'b1;
        rx_ovr_d   = rx_valid_q & ~rx_ready;
`ifdef UART_PARITY_EN
        rx_perr_d  = rx_pbad_q;
`endif
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q    <= TX_IDLE;
      tx_ovs_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_stop2_q <= 1'b0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_ovs_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_ovs_q   <= tx_ovs_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_stop2_q <= tx_stop2_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      rx_ovs_q   <= rx_ovs_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_pen_q  <= 1'b0;
      tx_par_q  <= 1'b0;
      rx_pen_q  <= 1'b0;
      rx_odd_q  <= 1'b0;
      rx_pbad_q <= 1'b0;
      rx_perr_q <= 1'b0;
    end else begin
      tx_pen_q  <= tx_pen_d;
      tx_par_q  <= tx_par_d;
      rx_pen_q  <= rx_pen_d;
      rx_odd_q  <= rx_odd_d;
      rx_pbad_q <= rx_pbad_d;
      rx_perr_q <= rx_perr_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: scoreboard bench for uart_core_param.
// Loopback and bench-driven serial frames on rx.
module tb_uart_core_param;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   baud_div;
  logic          stop2, par_en, par_odd;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready, tx, rx;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_ready, rx_ferr, rx_perr, rx_ovr;
  logic          rx_mode, rx_drv;

  int total = 0;
  int bad = 0;
  int ovr_cnt = 0;
  logic [DW-1:0] sb[$];

  assign rx = rx_mode ? rx_drv : tx;

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_ovr) ovr_cnt++;

  uart_core_param #(.DATA_W(DW), .DIV_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .stop2    (stop2),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_ferr  (rx_ferr),
    .rx_perr  (rx_perr),
    .rx_ovr   (rx_ovr)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rxv(input int lim, output bit ok);
    int n;
    n = 0;
    while (!rx_valid && n < lim) begin
      cyc(1);
      n++;
    end
    ok = rx_valid;
  endtask

  task automatic wait_txr(input int lim, output bit ok);
    int n;
    n = 0;
    while (!tx_ready && n < lim) begin
      cyc(1);
      n++;
    end
    ok = tx_ready;
  endtask

  task automatic send_tx(input logic [DW-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    sb.push_back(d);
  endtask

  task automatic send_rx(input logic [8:0] d, input int nb,
                         input bit use_par, input logic pbit,
                         input logic sbit, input int bc);
    rx_drv = 1'b0;
    cyc(bc);
    for (int i = 0; i < nb; i++) begin
      rx_drv = d[i];
      cyc(bc);
    end
    if (use_par) begin
      rx_drv = pbit;
      cyc(bc);
    end
    rx_drv = sbit;
    cyc(bc);
    rx_drv = 1'b1;
  endtask

  task automatic consume;
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    total++;
    if (tx !== 1'b1) begin
      bad++; $display("FAIL reset_tx got=%b want=1", tx);
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready);
    end
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid);
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data);
    end
    total++;
    if ({rx_ferr, rx_perr, rx_ovr} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000",
               {rx_ferr, rx_perr, rx_ovr});
    end
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_tx_frame;
    logic [7:0] pat;
    int n;
    pat = 8'hA5;
    baud_div = 16'd26;
    stop2 = 1'b0;
    cyc(2);
    tx_data  = pat;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    total++;
    if (tx !== 1'b0 || tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL tx_accept got tx=%b rdy=%b want tx=0 rdy=0",
               tx, tx_ready);
    end
    n = 0;
    while (tx === 1'b0 && n < 600) begin
      cyc(1);
      n++;
    end
    total++;
    if (n < 15 * 27 + 1 || n > 16 * 27) begin
      bad++;
      $display("FAIL tx_start_len got=%0d want=%0d..%0d",
               n, 15 * 27 + 1, 16 * 27);
    end
    cyc(215);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (tx !== pat[i]) begin
        bad++; $display("FAIL tx_bit%0d got=%b want=%b", i, tx, pat[i]);
      end
      cyc(432);
    end
    total++;
    if (tx !== 1'b1) begin
      bad++; $display("FAIL tx_stop got=%b want=1", tx);
    end
    cyc(218);
    total++;
    if (tx_ready !== 1'b1) begin
      bad++; $display("FAIL tx_ready_back got=%b want=1", tx_ready);
    end
  endtask

  task automatic test_loopback_sweep;
    bit ok;
    int ovr0;
    logic [7:0] exp;
    baud_div = 16'd0;
    stop2 = 1'b1;
    rx_mode = 1'b0;
    ovr0 = ovr_cnt;
    cyc(4);
    for (int v = 0; v < 256; v++) begin
      wait_txr(500, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL sweep_tx_ready got=0 want=1 v=%0d", v);
      end
      send_tx(8'(v));
      wait_rxv(400, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL sweep_rx_timeout got=0 want=1 v=%0d", v);
        sb.delete();
      end else begin
        exp = sb.pop_front();
        total++;
        if (rx_data !== exp) begin
          bad++; $display("FAIL sweep_data got=%h want=%h", rx_data, exp);
        end
        total++;
        if (rx_ferr !== 1'b0 || rx_perr !== 1'b0) begin
          bad++;
          $display("FAIL sweep_flags got=%b%b want=00", rx_ferr, rx_perr);
        end
        consume();
      end
    end
    total++;
    if (ovr_cnt !== ovr0) begin
      bad++; $display("FAIL sweep_ovr got=%0d want=%0d", ovr_cnt, ovr0);
    end
    wait_txr(500, ok);
    stop2 = 1'b0;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    bit ok;
    logic [7:0] exp;
    baud_div = 16'd0;
    par_en = 1'b1;
    par_odd = 1'b1;
    rx_mode = 1'b0;
    cyc(4);
    send_tx(8'h03);
    cyc(151);
    total++;
    if (tx !== 1'b1) begin
      bad++; $display("FAIL par_bit got=%b want=1", tx);
    end
    wait_rxv(300, ok);
    exp = sb.pop_front();
    total++;
    if (!ok || rx_data !== exp || rx_perr !== 1'b0) begin
      bad++;
      $display("FAIL par_loop got=%h/%b want=%h/0", rx_data, rx_perr, exp);
    end
    consume();
    wait_txr(300, ok);
    rx_mode = 1'b1;
    rx_drv = 1'b1;
    cyc(20);
    sb.push_back(8'h03);
    send_rx(9'h003, 8, 1'b1, 1'b0, 1'b1, 16);
    wait_rxv(100, ok);
    exp = sb.pop_front();
    total++;
    if (!ok || rx_perr !== 1'b1) begin
      bad++; $display("FAIL par_flip got=%b want=1", rx_perr);
    end
    total++;
    if (rx_data !== exp) begin
      bad++; $display("FAIL par_flip_data got=%h want=%h", rx_data, exp);
    end
    consume();
    par_en = 1'b0;
    par_odd = 1'b0;
  endtask
`endif

  task automatic test_framing;
    bit ok;
    int ovr0;
    logic [7:0] exp;
    baud_div = 16'd1;
    rx_mode = 1'b1;
    rx_drv = 1'b1;
    cyc(40);
    sb.push_back(8'h55);
    send_rx(9'h055, 8, 1'b0, 1'b0, 1'b0, 32);
    cyc(4);
    wait_rxv(100, ok);
    exp = sb.pop_front();
    total++;
    if (!ok || rx_ferr !== 1'b1) begin
      bad++; $display("FAIL ferr got=%b/%b want=1/1", rx_valid, rx_ferr);
    end
    total++;
    if (rx_data !== exp) begin
      bad++; $display("FAIL ferr_data got=%h want=%h", rx_data, exp);
    end
    consume();
    cyc(40);
    ovr0 = ovr_cnt;
    rx_drv = 1'b0;
    cyc(3 * 10 * 32);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h00 || rx_ferr !== 1'b1) begin
      bad++;
      $display("FAIL break_word got=%b/%h/%b want=1/00/1",
               rx_valid, rx_data, rx_ferr);
    end
    total++;
    if (ovr_cnt !== ovr0) begin
      bad++; $display("FAIL break_count got=%0d want=%0d", ovr_cnt, ovr0);
    end
    consume();
    cyc(200);
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL break_restart got=%b want=0", rx_valid);
    end
    rx_drv = 1'b1;
    cyc(200);
    sb.push_back(8'h81);
    send_rx(9'h081, 8, 1'b0, 1'b0, 1'b1, 32);
    wait_rxv(100, ok);
    exp = sb.pop_front();
    total++;
    if (!ok || rx_data !== exp || rx_ferr !== 1'b0) begin
      bad++;
      $display("FAIL break_rearm got=%h/%b want=%h/0", rx_data, rx_ferr, exp);
    end
    consume();
  endtask

  task automatic test_glitch;
    bit ok;
    logic [7:0] exp;
    cyc(40);
    rx_drv = 1'b0;
    cyc(8);
    rx_drv = 1'b1;
    cyc(400);
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL glitch got=%b want=0", rx_valid);
    end
    sb.push_back(8'h7E);
    send_rx(9'h07E, 8, 1'b0, 1'b0, 1'b1, 32);
    wait_rxv(100, ok);
    exp = sb.pop_front();
    total++;
    if (!ok || rx_data !== exp || rx_ferr !== 1'b0) begin
      bad++;
      $display("FAIL glitch_next got=%h/%b want=%h/0", rx_data, rx_ferr, exp);
    end
    consume();
  endtask

  task automatic test_back_to_back;
    int ovr0;
    logic [7:0] exp;
    cyc(40);
    ovr0 = ovr_cnt;
    sb.push_back(8'h3C);
    send_rx(9'h03C, 8, 1'b0, 1'b0, 1'b1, 32);
    cyc(10);
    sb.push_back(8'hC3);
    send_rx(9'h0C3, 8, 1'b0, 1'b0, 1'b1, 32);
    cyc(10);
    void'(sb.pop_front());
    exp = sb.pop_front();
    total++;
    if (ovr_cnt !== ovr0 + 1) begin
      bad++; $display("FAIL ovr_pulse got=%0d want=%0d", ovr_cnt, ovr0 + 1);
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== exp) begin
      bad++;
      $display("FAIL ovr_data got=%b/%h want=1/%h", rx_valid, rx_data, exp);
    end
    consume();
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [7:0] exp;
    baud_div = 16'd1;
    rx_mode = 1'b0;
    cyc(10);
    send_tx(8'h11);
    wait_rxv(600, ok);
    wait_txr(600, ok);
    sb.delete();
    send_tx(8'h5A);
    cyc(112);
    total++;
    if (tx !== 1'b0 || rx_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst got=%b/%b want=0/1", tx, rx_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_tx got=%b/%b want=1/1", tx, tx_ready);
    end
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_rx got=%b want=0", rx_valid);
    end
    sb.delete();
    cyc(3);
    rst = 1'b0;
    cyc(3);
    send_tx(8'h96);
    wait_rxv(600, ok);
    exp = sb.pop_front();
    total++;
    if (!ok || rx_data !== exp || rx_ferr !== 1'b0) begin
      bad++;
      $display("FAIL rst_after got=%h/%b want=%h/0", rx_data, rx_ferr, exp);
    end
    consume();
  endtask

  initial begin
    rst = 1'b1;
    baud_div = 16'd26;
    stop2 = 1'b0;
    par_en = 1'b0;
    par_odd = 1'b0;
    tx_data = '0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    rx_mode = 1'b1;
    rx_drv = 1'b1;
    test_reset();
    test_tx_frame();
    test_loopback_sweep();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
